call_panel: RTL and testbench
=============================

// Module: call_panel
// PURPOSE
//  Request side of the elevator call interface. Synchronises and debounces raw floor-call buttons,
//  latches them as pending calls and offers one call at a time to the elevator controller over a
//  valid/ready handshake. Clears calls when the controller reports a floor served. Drives the call LEDs.
// PARAMETERS
//  N_FLOORS         5        number of floors; floor codes are 1..N_FLOORS
//  FLOOR_W          3        width of a floor code
//  DEBOUNCE_CYCLES  500000   stable-level cycles before a button edge is accepted (10 ms @ 50 MHz)
// PORTS
//  CLOCK_50      in   1         system clock; all state on its rising edge
//  RESET         in   1         asynchronous, active-high reset
//  btn_in        in   N_FLOORS  raw asynchronous call buttons, active-high; bit i = floor i+1
//  emergency     in   1         controller emergency mode; level-sensitive
//  req_valid     out  1         a call is being offered
//  req_floor     out  FLOOR_W   offered floor code (1-based); 0 when req_valid=0
//  req_ready     in   1         controller accepts the offered call
//  served_valid  in   1         one-cycle strobe: controller stopped at served_floor
//  served_floor  in   FLOOR_W   floor just served (1-based)
//  pending       out  N_FLOORS  latched calls, for LEDR
//  busy          out  1         an accepted call is still waiting to be served
// BEHAVIOUR
//  Reset: pending=0, req_valid=0, req_floor=0, busy=0, FSM=IDLE, rr_ptr=0, debounced levels=0.
//  Input path per button:
//   - 2-flop synchroniser.
//   - Debounce counter restarts on every change of the synchronised level.
//   - Debounced level updates after DEBOUNCE_CYCLES consecutive equal samples.
//   - A 0->1 edge of the debounced level sets pending[i] on the next edge.
//  Clearing:
//   - served_valid clears pending[served_floor-1] for any floor.
//   - served_floor of 0 or >N_FLOORS is ignored.
//   - A set and a clear of the same bit in the same cycle: clear wins.
//  Emergency high: pending forced to 0 every cycle; new edges are dropped, not queued.
//   - FSM goes to IDLE on the next edge.
//   - req_valid deasserts on the next edge, even mid-handshake.
//   - Debouncers keep running.
//  FSM:
//   - IDLE: if pending!=0 and !emergency, pick a floor by round-robin. Search starts at index
//     rr_ptr and wraps N_FLOORS-1 -> 0. Latch the floor into req_floor, go to OFFER.
//     req_valid is high the cycle after the pending bit is set.
//   - OFFER: req_valid=1; req_floor held stable until accepted.
//     * req_valid & req_ready: go to WAIT, busy=1, rr_ptr = granted index + 1 (mod N_FLOORS).
//     * Offered bit cleared by served_valid before acceptance: drop req_valid, go to IDLE.
//   - WAIT: req_valid=0, req_floor=0.
//     * served_valid with served_floor == granted floor: bit cleared, busy=0, go to IDLE.
//     * Served strobes for other floors only clear their own bits.
//  Timing: press to req_valid = 2 (sync) + DEBOUNCE_CYCLES + 2 cycles.
//   No combinational path from req_ready to req_valid.
//  A held button raises exactly one call. Re-pressing a pending floor has no effect.
//  All floor arithmetic is FLOOR_W bits, index = code-1. rr_ptr uses an explicit wrap, not a power-of-2 overflow.
// STRUCTURE
//  Shared include elevator_defs.vh: N_FLOORS, FLOOR_W, floor-code <-> index macros, call_panel FSM
//  state localparams (IDLE=2'b00, OFFER=2'b01, WAIT=2'b10). The controller uses the same floor encoding.
//  Sub-module debounce_sync (synchroniser + counter + rising-edge pulse), one instance per floor
//  via generate. Round-robin selection and FSM stay in call_panel.
// TESTING  (DEBOUNCE_CYCLES=4, N_FLOORS=5)
//  1 Reset mid-OFFER: assert RESET asynchronously -> req_valid=0, req_floor=0, pending=0 at once,
//    with no clock edge.
//  2 btn_in[2] high for 3 cycles, then low -> no pending bit. btn_in[2] held 10 cycles with 1-cycle
//    glitches after it settles -> pending=00100 once, req_valid=1 with req_floor=3, req_ready=0 for
//    5 cycles -> req_floor stays 3.
//  3 pending=10001, rr_ptr=0 -> first offer is floor 1. After accept and serve -> next offer is
//    floor 5, rr_ptr=0 after accepting it.
//  4 In WAIT for floor 4: served_floor=2 strobe -> pending[1] clears, busy stays 1.
//    Then served_floor=4 -> pending[3]=0, busy=0, FSM=IDLE.
//  5 Same cycle: debounced edge on floor 3 and served_floor=3 -> pending[2]=0 (clear wins).
//    served_floor=0 or 7 -> no change.
//  6 emergency=1 during OFFER with pending=01110 -> next edge req_valid=0, pending=0. Presses during
//    emergency -> no pending. emergency=0 -> new presses work normally.

Source files
------------

// File: rtl/call_panel_pkg.sv
// Shared definitions for the elevator call panel: default sizing and FSM states.
// The controller uses the same 1-based floor codes; index = code - 1.
// Ports: none (package only).
package call_panel_pkg;

  localparam int N_FLOORS_DEF        = 5;
  localparam int FLOOR_W_DEF         = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;  // 10 ms at 50 MHz

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OFFER = 2'b01,
    WAIT  = 2'b10
  } panel_state_t;

endpackage

// File: rtl/debounce_sync.sv
// Purpose: synchronise one raw button, debounce it, pulse on an accepted rising edge.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples; rise pulses with the level change.
// Backpressure: none; free-running per button.
// Ports: CLOCK_50/RESET clock and async reset; btn raw input; rise one-cycle 0->1 pulse.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronised sample disagrees with the
  // accepted level; any return to the accepted level restarts it, so a flip
  // needs DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      rise   <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_b;
        rise  <= sync_b;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/call_panel.sv
// Purpose: latch debounced floor calls and offer them one at a time, round-robin, to the controller.
// Latency: press to req_valid = 2 + DEBOUNCE_CYCLES + 2 cycles; req_valid is registered (no path from req_ready).
// Backpressure: offer held with a stable floor until req_ready; calls keep latching meanwhile.
// Ports: CLOCK_50, RESET (async high); btn_in raw buttons; emergency level; req_valid/req_floor/req_ready
//        offer handshake; served_valid/served_floor served strobe; pending call LEDs; busy accepted-not-served.
module call_panel
  import call_panel_pkg::*;
#(
  parameter int N_FLOORS        = N_FLOORS_DEF,
  parameter int FLOOR_W         = FLOOR_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [N_FLOORS-1:0] btn_in,
  input  logic                emergency,
  output logic                req_valid,
  output logic [FLOOR_W-1:0]  req_floor,
  input  logic                req_ready,
  input  logic                served_valid,
  input  logic [FLOOR_W-1:0]  served_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy
);

  localparam logic [FLOOR_W-1:0] LAST_IDX = FLOOR_W'(N_FLOORS - 1);

  panel_state_t        state, state_d;
  logic [FLOOR_W-1:0]  floor_idx, floor_idx_d;  // index of the offered / granted floor
  logic [FLOOR_W-1:0]  rr_ptr, rr_ptr_d;
  logic [N_FLOORS-1:0] rise;
  logic [N_FLOORS-1:0] clr;
  logic [N_FLOORS-1:0] pending_d;
  logic                pick_found;
  logic [FLOOR_W-1:0]  pick_idx;

  for (genvar i = 0; i < N_FLOORS; i++) begin : g_btn
    debounce_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .CLOCK_50(CLOCK_50),
      .RESET   (RESET),
      .btn     (btn_in[i]),
      .rise    (rise[i])
    );
  end

  // Decode the served strobe; codes 0 and above N_FLOORS match no bit.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (served_valid && (served_floor == FLOOR_W'(i + 1))) clr[i] = 1'b1;
    end
  end

  // Clear beats set; emergency flushes everything and drops new edges.
  assign pending_d = emergency ? '0 : ((pending | rise) & ~clr);

  // Round-robin search from rr_ptr with an explicit wrap at the top floor.
  always_comb begin
    logic [FLOOR_W-1:0] j;
    pick_found = 1'b0;
    pick_idx   = '0;
    j          = rr_ptr;
    for (int k = 0; k < N_FLOORS; k++) begin
      if (!pick_found && pending[j]) begin
        pick_found = 1'b1;
        pick_idx   = j;
      end
      j = (j == LAST_IDX) ? '0 : j + FLOOR_W'(1);
    end
  end

  always_comb begin
    state_d     = state;
    floor_idx_d = floor_idx;
    rr_ptr_d    = rr_ptr;
    if (emergency) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            state_d     = OFFER;
            floor_idx_d = pick_idx;
          end
        end
        OFFER: begin
          // A call served (or already gone) before acceptance is withdrawn.
          if (clr[floor_idx] || !pending[floor_idx]) begin
            state_d = IDLE;
          end else if (req_ready) begin
            state_d  = WAIT;
            rr_ptr_d = (floor_idx == LAST_IDX) ? '0 : floor_idx + FLOOR_W'(1);
          end
        end
        WAIT: begin
          if (clr[floor_idx]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      floor_idx <= '0;
      rr_ptr    <= '0;
      pending   <= '0;
    end else begin
      state     <= state_d;
      floor_idx <= floor_idx_d;
      rr_ptr    <= rr_ptr_d;
      pending   <= pending_d;
    end
  end

  assign req_valid = (state == OFFER);
  assign req_floor = (state == OFFER) ? floor_idx + FLOOR_W'(1) : '0;
  assign busy      = (state == WAIT);

endmodule

// File: tb/tb_call_panel.sv
// Bench for call_panel with a short debounce window: directed scenarios followed by
// random button / handshake / served / emergency traffic against a floor-level model.
module tb_call_panel;

  localparam int N  = 5;
  localparam int FW = 3;
  localparam int D  = 4;

  logic          CLOCK_50 = 1'b0;
  logic          RESET;
  logic [N-1:0]  btn_in;
  logic          emergency;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic          req_ready;
  logic          served_valid;
  logic [FW-1:0] served_floor;
  logic [N-1:0]  pending;
  logic          busy;

  call_panel #(
    .N_FLOORS(N),
    .FLOOR_W(FW),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .btn_in      (btn_in),
    .emergency   (emergency),
    .req_valid   (req_valid),
    .req_floor   (req_floor),
    .req_ready   (req_ready),
    .served_valid(served_valid),
    .served_floor(served_floor),
    .pending     (pending),
    .busy        (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: button sample history, accepted levels, and the call
  // bookkeeping expressed as "floor on offer" / "floor granted" codes (0 = none).
  logic [N-1:0] hist [0:D];   // hist[0] = sample taken at the latest edge
  logic [N-1:0] m_deb;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_pend;
  int           m_offer;
  int           m_grant;
  int           m_rr;

  task automatic model_reset();
    for (int k = 0; k <= D; k++) hist[k] = '0;
    m_deb   = '0;
    m_rise  = '0;
    m_pend  = '0;
    m_offer = 0;
    m_grant = 0;
    m_rr    = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] set_v;
    logic [N-1:0] clr_v;
    logic [N-1:0] new_rise;
    logic [N-1:0] old;
    bit           flip;
    int           j;
    set_v    = m_rise;
    new_rise = '0;
    // A level flips once the D synchronised samples (2 edges stale) all disagree with it.
    for (int i = 0; i < N; i++) begin
      flip = 1'b1;
      for (int k = 1; k <= D; k++) if (hist[k][i] == m_deb[i]) flip = 1'b0;
      if (flip) begin
        new_rise[i] = !m_deb[i];
        m_deb[i]    = !m_deb[i];
      end
    end
    for (int k = D; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = btn_in;
    m_rise  = new_rise;

    clr_v = '0;
    if (served_valid && served_floor >= 1 && int'(served_floor) <= N)
      clr_v[int'(served_floor) - 1] = 1'b1;

    old = m_pend;
    if (emergency) begin
      m_pend  = '0;
      m_offer = 0;
      m_grant = 0;
    end else begin
      m_pend = (m_pend | set_v) & ~clr_v;
      if (m_offer != 0) begin
        if (clr_v[m_offer-1] || !old[m_offer-1]) m_offer = 0;
        else if (req_ready) begin
          m_grant = m_offer;
          m_rr    = m_offer % N;
          m_offer = 0;
        end
      end else if (m_grant != 0) begin
        if (clr_v[m_grant-1]) m_grant = 0;
      end else if (old != '0) begin
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (m_offer == 0 && old[j]) m_offer = j + 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    if (RESET) model_reset();
    else model_edge();
    #1;
    check("req_valid", req_valid, (m_offer != 0));
    check("req_floor", req_floor, m_offer);
    check("busy", busy, (m_grant != 0));
    check("pending", pending, m_pend);
  endtask

  task automatic wait_offer(input string tag);
    int n;
    n = 0;
    while (!req_valid && n < 30) begin
      tick();
      n++;
    end
    check(tag, req_valid, 1);
  endtask

  task automatic accept_and_serve();
    logic [FW-1:0] f;
    f = req_floor;
    req_ready = 1'b1;
    tick();
    req_ready    = 1'b0;
    served_valid = 1'b1;
    served_floor = f;
    tick();
    served_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET        = 1'b1;
    btn_in       = '0;
    emergency    = 1'b0;
    req_ready    = 1'b0;
    served_valid = 1'b0;
    served_floor = '0;
    model_reset();
    #3;
    check("rst_valid", req_valid, 0);
    check("rst_floor", req_floor, 0);
    check("rst_pending", pending, 0);
    check("rst_busy", busy, 0);
    repeat (2) tick();
    RESET = 1'b0;

    // Short press is filtered, then a long press with glitches raises one call.
    btn_in = 5'b00100;
    repeat (3) tick();
    btn_in = '0;
    repeat (10) tick();
    check("short_press", pending, 0);
    btn_in = 5'b00100;
    repeat (7) tick();
    check("t2_pending", pending, 5'b00100);
    check("t2_not_yet", req_valid, 0);
    tick();
    check("t2_latency", req_valid, 1);
    check("t2_floor", req_floor, 3);
    for (int g = 0; g < 5; g++) begin
      btn_in = (g == 0 || g == 3) ? 5'b00000 : 5'b00100;
      tick();
      check("t2_hold_floor", req_floor, 3);
      check("t2_hold_pend", pending, 5'b00100);
    end
    btn_in = '0;

    // Asynchronous reset while offering.
    #4;
    RESET = 1'b1;
    #1;
    model_reset();
    check("arst_valid", req_valid, 0);
    check("arst_floor", req_floor, 0);
    check("arst_pending", pending, 0);
    repeat (2) tick();
    RESET = 1'b0;
    tick();

    // Round robin with wrap.
    btn_in = 5'b10001;
    wait_offer("t3_offer1");
    check("t3_first", req_floor, 1);
    check("t3_pend", pending, 5'b10001);
    btn_in = '0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("t3_busy", busy, 1);
    served_valid = 1'b1;
    served_floor = 3'd1;
    tick();
    served_valid = 1'b0;
    check("t3_unbusy", busy, 0);
    wait_offer("t3_offer2");
    check("t3_second", req_floor, 5);
    accept_and_serve();
    repeat (8) tick();
    btn_in = 5'b10001;
    wait_offer("t3_offer3");
    check("t3_rr_wrap", req_floor, 1);
    btn_in = '0;
    accept_and_serve();
    wait_offer("t3_offer4");
    accept_and_serve();
    repeat (8) tick();

    // Serve strobes while waiting on floor 4.
    btn_in = 5'b01000;
    wait_offer("t4_offer");
    check("t4_floor", req_floor, 4);
    btn_in = '0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    btn_in = 5'b00010;
    repeat (8) tick();
    btn_in = '0;
    check("t4_pend", pending, 5'b01010);
    served_valid = 1'b1;
    served_floor = 3'd2;
    tick();
    check("t4_other_clear", pending, 5'b01000);
    check("t4_still_busy", busy, 1);
    served_floor = 3'd4;
    tick();
    served_valid = 1'b0;
    check("t4_done_pend", pending, 0);
    check("t4_done_busy", busy, 0);
    tick();
    check("t4_idle", req_valid, 0);
    repeat (8) tick();

    // Clear wins over a same-cycle set; out-of-range serves ignored.
    btn_in = 5'b00100;
    repeat (6) tick();
    served_valid = 1'b1;
    served_floor = 3'd3;
    tick();
    served_valid = 1'b0;
    check("t5_clear_wins", pending, 0);
    tick();
    check("t5_no_offer", req_valid, 0);
    btn_in = 5'b00001;
    wait_offer("t5_offer");
    btn_in = '0;
    served_valid = 1'b1;
    served_floor = 3'd0;
    tick();
    check("t5_serve0", pending, 5'b00001);
    served_floor = 3'd7;
    tick();
    served_valid = 1'b0;
    check("t5_serve7", pending, 5'b00001);
    check("t5_still_offer", req_valid, 1);
    accept_and_serve();
    repeat (8) tick();

    // Emergency flushes and drops presses.
    btn_in = 5'b01110;
    wait_offer("t6_offer");
    check("t6_pend", pending, 5'b01110);
    emergency = 1'b1;
    tick();
    check("t6_valid_drop", req_valid, 0);
    check("t6_flush", pending, 0);
    btn_in = '0;
    repeat (8) tick();
    btn_in = 5'b00001;
    repeat (10) tick();
    check("t6_dropped", pending, 0);
    btn_in = '0;
    repeat (8) tick();
    emergency = 1'b0;
    tick();
    check("t6_after", pending, 0);
    btn_in = 5'b10000;
    wait_offer("t6_recover");
    check("t6_floor", req_floor, 5);
    btn_in = '0;
    accept_and_serve();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 29) == 0) btn_in[i] = ~btn_in[i];
      req_ready    = ($urandom_range(0, 2) == 0);
      served_valid = ($urandom_range(0, 5) == 0);
      if (m_grant != 0 && $urandom_range(0, 1) == 1) served_floor = FW'(m_grant);
      else served_floor = FW'($urandom_range(0, 7));
      if (emergency) emergency = ($urandom_range(0, 15) != 0);
      else emergency = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
